// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan display: hex decode table,
// segment-off pattern and digit count.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-high 7-segment decode ({g,f,e,d,c,b,a}).
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[nib];

endmodule

// File: rtl/seg_scan16.sv
// Four-digit multiplexed hex display of a captured 16-bit value, with a
// per-slot blanking guard, optional leading-zero blanking and frame-aligned updates.
module seg_scan16
  import seg_pkg::*;
#(
  parameter int CLK_DIV        = 1000,
  parameter bit BLANK_LZ       = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic [15:0] DATA,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic [3:0]  AN,
  output logic        FRAME
);

  localparam int               CNT_W      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [1:0]       LAST_DIGIT = 2'(NUM_DIGITS - 1);

  generate
    if (CLK_DIV < 2) begin : g_clk_div_check
      $error("seg_scan16: CLK_DIV must be >= 2");
    end
  endgenerate

  function automatic logic [6:0] seg_pol(input logic [6:0] s);
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  function automatic logic dp_pol(input logic lit);
    return SEG_ACTIVE_LOW ? ~lit : lit;
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      shadow;
  logic [15:0]      disp;
  logic             wrap;
  logic             frame_edge;
  logic [3:0]       nib;
  logic [6:0]       hex_seg;
  logic             lz_blank;
  logic             blank;
  logic [6:0]       seg_nxt;
  logic [3:0]       an_nxt;
  logic             dp_nxt;

  assign wrap       = (cnt == CNT_LAST);
  assign frame_edge = wrap && (idx == LAST_DIGIT);

  // Prescaler and digit index
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
      idx <= '0;
    end else if (wrap) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow takes every strobe; display only moves on a frame boundary
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shadow <= '0;
      disp   <= '0;
    end else begin
      if (EN) begin
        shadow <= DATA;
      end
      if (frame_edge) begin
        disp <= shadow;
      end
    end
  end

  hex7seg u_hex7seg (
    .nib (nib),
    .seg (hex_seg)
  );

  always_comb begin
    nib      = 4'h0;
    lz_blank = 1'b0;
    case (idx)
      2'd0: nib = disp[3:0];
      2'd1: begin
        nib      = disp[7:4];
        lz_blank = (disp[15:4] == 12'h000);
      end
      2'd2: begin
        nib      = disp[11:8];
        lz_blank = (disp[15:8] == 8'h00);
      end
      default: begin
        nib      = disp[15:12];
        lz_blank = (disp[15:12] == 4'h0);
      end
    endcase

    // cnt==0 is the inter-digit ghosting guard
    blank   = (cnt == '0) || (BLANK_LZ && lz_blank);
    seg_nxt = blank ? SEG_OFF : hex_seg;
    an_nxt  = blank ? 4'hF : ~(4'b0001 << idx);
    dp_nxt  = (idx == 2'd0) && (shadow != disp);
  end

  // Output register stage: pins lag cnt/idx by one cycle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      SEG   <= seg_pol(SEG_OFF);
      DP    <= dp_pol(1'b0);
      AN    <= 4'hF;
      FRAME <= 1'b0;
    end else begin
      SEG   <= seg_pol(seg_nxt);
      DP    <= dp_pol(dp_nxt);
      AN    <= an_nxt;
      FRAME <= frame_edge;
    end
  end

endmodule
